// File: rtl/grill_star_plant.sv
// Grill/star mechanism plant: converts motor commands into travel counters,
// decodes position sensor codes and flags illegal or interlocked commands.
module grill_star_plant #(
    parameter int GRILL_TRAVEL = 16,
    parameter int STAR_TRAVEL  = 12,
    parameter int CNT_W        = 8,
    parameter int INIT_GRILL   = 0,
    parameter int INIT_STAR    = 0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_motor_cmd,
    input  logic       i_stall,
    output logic [1:0] o_grill_pos,
    output logic [1:0] o_star_pos,
    output logic       o_fault,
    output logic [1:0] o_fault_code
);

    localparam logic [CNT_W-1:0] LP_G_END  = CNT_W'(GRILL_TRAVEL);
    localparam logic [CNT_W-1:0] LP_S_END  = CNT_W'(STAR_TRAVEL);
    localparam logic [CNT_W-1:0] LP_G_INIT = (INIT_GRILL != 0) ? LP_G_END : '0;
    localparam logic [CNT_W-1:0] LP_S_INIT = (INIT_STAR != 0) ? LP_S_END : '0;
    localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] r_g_cnt;
    logic [CNT_W-1:0] r_s_cnt;
    logic             r_fault;
    logic [1:0]       r_fault_code;

    logic w_multi;
    logic w_grill_cmd;
    logic w_star_cmd;
    logic w_star_mid;
    logic w_grill_open;
    logic w_interlock;
    logic w_move_ok;

    // Clearing the lowest set bit leaves a nonzero value iff two or more bits are set.
    assign w_multi      = (i_motor_cmd & (i_motor_cmd - 4'd1)) != 4'd0;
    assign w_grill_cmd  = i_motor_cmd[3] | i_motor_cmd[2];
    assign w_star_cmd   = i_motor_cmd[1] | i_motor_cmd[0];
    assign w_star_mid   = (r_s_cnt != '0) && (r_s_cnt != LP_S_END);
    assign w_grill_open = (r_g_cnt == LP_G_END);
    assign w_interlock  = !w_multi &&
                          ((w_grill_cmd && w_star_mid) || (w_star_cmd && !w_grill_open));
    assign w_move_ok    = !i_stall && !w_multi && !w_interlock;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_g_cnt      <= LP_G_INIT;
            r_s_cnt      <= LP_S_INIT;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
        end else begin
            if ((w_multi || w_interlock) && !r_fault) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_multi ? 2'b01 : 2'b10;
            end
            if (w_move_ok) begin
                if (i_motor_cmd[3] && r_g_cnt != LP_G_END) r_g_cnt <= r_g_cnt + LP_ONE;
                if (i_motor_cmd[2] && r_g_cnt != '0)       r_g_cnt <= r_g_cnt - LP_ONE;
                if (i_motor_cmd[1] && r_s_cnt != LP_S_END) r_s_cnt <= r_s_cnt + LP_ONE;
                if (i_motor_cmd[0] && r_s_cnt != '0)       r_s_cnt <= r_s_cnt - LP_ONE;
            end
        end
    end

    always_comb begin
        o_grill_pos = 2'b10;
        if (r_g_cnt == '0)            o_grill_pos = 2'b00;
        else if (r_g_cnt == LP_G_END) o_grill_pos = 2'b01;
        o_star_pos = 2'b10;
        if (r_s_cnt == '0)            o_star_pos = 2'b00;
        else if (r_s_cnt == LP_S_END) o_star_pos = 2'b01;
    end

    assign o_fault      = r_fault;
    assign o_fault_code = r_fault_code;

endmodule

// File: tb/tb_grill_star_plant.sv
// Scoreboard bench for grill_star_plant: directed scenarios then randomized
// command streams, checked against a position/fault reference model.
module tb_grill_star_plant;

    localparam int GT = 16;
    localparam int ST = 12;

    logic       clk;
    logic       rst_n;
    logic [3:0] cmd;
    logic       stall;
    logic [1:0] grill_pos;
    logic [1:0] star_pos;
    logic       fault;
    logic [1:0] fault_code;

    grill_star_plant #(
        .GRILL_TRAVEL(GT),
        .STAR_TRAVEL (ST),
        .CNT_W       (8),
        .INIT_GRILL  (0),
        .INIT_STAR   (0)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_motor_cmd (cmd),
        .i_stall     (stall),
        .o_grill_pos (grill_pos),
        .o_star_pos  (star_pos),
        .o_fault     (fault),
        .o_fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] g;
        logic [1:0] s;
        logic       f;
        logic [1:0] c;
        int         tag;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_push   = 0;
    int   n_pop    = 0;

    // Reference model state: physical positions in travel steps.
    int       m_g;
    int       m_s;
    bit       m_f;
    bit [1:0] m_c;

    function automatic logic [1:0] code_of(int p, int full);
        if (p == 0)    return 2'b00;
        if (p == full) return 2'b01;
        return 2'b10;
    endfunction

    task automatic model_reset();
        m_g = 0; m_s = 0; m_f = 1'b0; m_c = 2'b00;
    endtask

    task automatic raise_fault(bit [1:0] c);
        if (!m_f) begin
            m_f = 1'b1;
            m_c = c;
        end
    endtask

    task automatic compare(string name, int tag, logic [1:0] eg, logic [1:0] es,
                           logic ef, logic [1:0] ec);
        n_checks++;
        if (grill_pos === eg && star_pos === es && fault === ef && fault_code === ec)
            n_pass++;
        else
            $display("FAIL %s[%0d]: got grill=%b star=%b fault=%b code=%b, expected grill=%b star=%b fault=%b code=%b",
                     name, tag, grill_pos, star_pos, fault, fault_code, eg, es, ef, ec);
    endtask

    // Drive one command for the next rising edge and queue the expected result.
    task automatic step(logic [3:0] c, logic st, int tag);
        exp_t e;
        @(negedge clk);
        cmd   = c;
        stall = st;
        if ($countones(c) > 1) begin
            raise_fault(2'b01);
        end else if (c[3] || c[2]) begin
            if (m_s > 0 && m_s < ST) raise_fault(2'b10);
            else if (!st) m_g = c[3] ? ((m_g < GT) ? m_g + 1 : GT) : ((m_g > 0) ? m_g - 1 : 0);
        end else if (c[1] || c[0]) begin
            if (m_g != GT) raise_fault(2'b10);
            else if (!st) m_s = c[1] ? ((m_s < ST) ? m_s + 1 : ST) : ((m_s > 0) ? m_s - 1 : 0);
        end
        e.g = code_of(m_g, GT);
        e.s = code_of(m_s, ST);
        e.f = m_f;
        e.c = m_c;
        e.tag = tag;
        q.push_back(e);
        n_push++;
    endtask

    task automatic run(logic [3:0] c, logic st, int n, int tag);
        for (int i = 0; i < n; i++) step(c, st, tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must reset before any edge.
    task automatic pulse_reset(int tag);
        @(negedge clk);
        cmd   = 4'b0000;
        stall = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        compare("async_reset", tag, 2'b00, 2'b00, 1'b0, 2'b00);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: the plant presents a new output state after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                n_pop++;
                compare("scoreboard", e.tag, e.g, e.s, e.f, e.c);
            end
        end
    end

    initial begin
        int r;
        logic [3:0] rc;
        logic rs;
        rst_n = 1'b0;
        cmd   = 4'b0000;
        stall = 1'b0;
        model_reset();

        pulse_reset(0);
        run(4'b0000, 1'b0, 20, 1);                 // idle after reset
        run(4'b1000, 1'b0, 1, 2);                  // first edge -> in between
        run(4'b1000, 1'b0, 15, 2);                 // reaches open on edge 16
        run(4'b1000, 1'b0, 3, 2);                  // end stop: saturate, no fault
        run(4'b0010, 1'b0, 12, 3);                 // hide star
        run(4'b0100, 1'b0, 16, 3);                 // close grill, star stays hidden
        run(4'b0010, 1'b0, 2, 4);                  // star cmd with grill closed
        run(4'b1100, 1'b0, 2, 4);                  // later multi-bit keeps code 10
        run(4'b1000, 1'b0, 3, 4);                  // motion still evaluated after fault

        pulse_reset(5);
        run(4'b1100, 1'b0, 1, 5);
        run(4'b1000, 1'b0, 5, 5);
        run(4'b0000, 1'b0, 3, 5);
        run(4'b1000, 1'b1, 4, 5);                  // jam freezes grill at 5
        run(4'b0100, 1'b0, 2, 5);                  // reversal
        run(4'b1000, 1'b0, 5, 6);                  // g = 8
        pulse_reset(6);
        run(4'b0000, 1'b0, 2, 6);

        for (int blk = 0; blk < 6; blk++) begin
            pulse_reset(100 + blk);
            for (int i = 0; i < 250; i++) begin
                r = int'($urandom_range(0, 99));
                if (r < 4) begin
                    rc = 4'($urandom_range(0, 15));
                    if ($countones(rc) < 2) rc = 4'b0011;
                end else if (r < 14) rc = 4'b0000;
                else if (r < 46) rc = 4'b1000;
                else if (r < 64) rc = 4'b0100;
                else if (r < 84) rc = 4'b0010;
                else rc = 4'b0001;
                rs = ($urandom_range(0, 9) == 0);
                step(rc, rs, 100 + blk);
            end
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (q.size() == 0 && n_pop == n_push) n_pass++;
        else $display("FAIL drain: got pending=%0d popped=%0d, expected pending=0 popped=%0d",
                      q.size(), n_pop, n_push);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule
